serial_nibble_receiver: RTL and testbench

// - Upstream feeder of the 4-bit load-enabled Register stage: recovers UART-style serial frames into a parallel nibble.
// - Frame format: start bit (0), DATA_WIDTH data bits (LSB first), one stop bit (1).
// - On a good frame, drives Data and pulses Load for exactly one Clk cycle, so the Register captures the nibble.
// - Bad frames raise FrameErr and never assert Load.

---
 rtl/serial_nibble_receiver_pkg.sv | 6 +
 rtl/serial_nibble_receiver_bit_timer.sv | 19 +
 rtl/serial_nibble_receiver.sv | 65 ++++++
 tb/tb_serial_nibble_receiver.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/serial_nibble_receiver_pkg.sv
// serial_nibble_receiver_pkg: shared FSM state encoding and default frame geometry
package serial_nibble_receiver_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  localparam int DEF_CLKS_PER_BIT = 8;
  localparam int DEF_DATA_WIDTH = 4;
endpackage

// File: rtl/serial_nibble_receiver_bit_timer.sv
// bit_timer: per-bit cycle counter with clear, half-period and full-period ticks
module bit_timer
  import serial_nibble_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic half,
  output logic full
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt;
  assign half = cnt == W'(CLKS_PER_BIT / 2 - 1);
  assign full = cnt == W'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk)
    cnt <= (reset || clear || full) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/serial_nibble_receiver.sv
// serial_nibble_receiver: recovers start/data/stop serial frames into a parallel nibble with load strobe
module serial_nibble_receiver
  import serial_nibble_receiver_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  load,
  output logic                  frame_err,
  output logic                  busy
);
  localparam int IW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  state_t state, next_state;
  logic meta, rx, half, full, stop_ok, last_bit;
  logic [IW-1:0] idx;
  logic [DATA_WIDTH-1:0] shreg;
  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (next_state != state),
    .half  (half),
    .full  (full)
  );
  assign last_bit = idx == IW'(DATA_WIDTH - 1);
  assign busy = state != IDLE;
  // stop_ok holds STOP for one extra cycle so load and the return to IDLE land together
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = rx ? IDLE : START;
      START:   next_state = !half ? START : rx ? IDLE : DATA;
      DATA:    next_state = full && last_bit ? STOP : DATA;
      STOP:    next_state = stop_ok ? IDLE : (full && !rx) ? BREAK : STOP;
      BREAK:   next_state = rx ? IDLE : BREAK;
      default: next_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      meta      <= 1'b1;
      rx        <= 1'b1;
      state     <= IDLE;
      idx       <= '0;
      shreg     <= '0;
      data      <= '0;
      load      <= 1'b0;
      frame_err <= 1'b0;
      stop_ok   <= 1'b0;
    end else begin
      meta      <= serial_in;
      rx        <= meta;
      state     <= next_state;
      idx       <= state == DATA ? (full ? idx + 1'b1 : idx) : '0;
      if (state == DATA && full) shreg <= {rx, shreg[DATA_WIDTH-1:1]};
      stop_ok   <= state == STOP && full && rx;
      frame_err <= state == STOP && full && !rx;
      load      <= stop_ok;
      if (stop_ok) data <= shreg;
    end
  end
endmodule

// File: tb/tb_serial_nibble_receiver.sv
// tb_serial_nibble_receiver: randomized frames checked by a scoreboard queue and an independent monitor
module tb_serial_nibble_receiver;
  logic clk = 1'b0, reset = 1'b1, serial_in = 1'b1;
  logic [3:0] data;
  logic load, frame_err, busy;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {
    bit is_err;
    logic [3:0] d;
    int fall;
  } exp_t;
  exp_t q[$];
  logic [3:0] model = 4'h0;
  serial_nibble_receiver dut (
    .clk       (clk),
    .reset     (reset),
    .serial_in (serial_in),
    .data      (data),
    .load      (load),
    .frame_err (frame_err),
    .busy      (busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // fall is the first clock edge that sees the low start bit; a good load is due 47 edges later
  task automatic send(input logic [3:0] d, input bit stop, input int low_extra);
    exp_t e;
    e.is_err = !stop;
    e.d = stop ? d : model;
    e.fall = cyc + 1;
    if (stop) model = d;
    q.push_back(e);
    serial_in = 1'b0;
    tick(8);
    for (int i = 0; i < 4; i++) begin
      serial_in = d[i];
      tick(8);
    end
    serial_in = stop;
    tick(8);
    if (!stop) begin
      tick(low_extra);
      check("busy_in_break", busy, 1);
      serial_in = 1'b1;
      tick(8);
      check("busy_after_break", busy, 0);
    end
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    logic [3:0] cur;
    bit pl, pe;
    if (reset) begin
      cur = 4'h0;
      pl = 1'b0;
      pe = 1'b0;
    end else begin
      if (load || frame_err) begin
        check("strobe_exclusive", load && frame_err, 0);
        check("strobe_width", load ? pl : pe, 0);
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe: load=%0b frame_err=%0b, nothing expected", load, frame_err);
        end else begin
          e = q.pop_front();
          check("strobe_kind", frame_err, e.is_err);
          check("data", data, e.d);
          if (!e.is_err) check("load_latency", cyc - e.fall, 47);
          cur = e.d;
        end
      end
      check("data_hold", data, cur);
      pl = load;
      pe = frame_err;
    end
  end
  initial begin
    logic [3:0] d;
    tick(3);
    reset = 1'b0;
    check("rst_data", data, 0);
    check("rst_load", load, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    tick(4);
    send(4'hA, 1'b1, 0);
    tick(8);
    serial_in = 1'b0;
    tick(2);
    serial_in = 1'b1;
    tick(12);
    check("glitch_busy", busy, 0);
    check("glitch_data", data, 4'hA);
    send(4'h5, 1'b0, 12);
    check("bad_stop_data", data, 4'hA);
    send(4'h3, 1'b1, 0);
    send(4'hC, 1'b1, 0);
    tick(8);
    check("b2b_data", data, 4'hC);
    serial_in = 1'b0;
    tick(8);
    d = 4'h9;
    for (int i = 0; i < 2; i++) begin
      serial_in = d[i];
      tick(8);
    end
    serial_in = d[2];
    tick(4);
    reset = 1'b1;
    serial_in = 1'b1;
    tick(2);
    reset = 1'b0;
    model = 4'h0;
    tick(1);
    check("midrst_data", data, 0);
    check("midrst_load", load, 0);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_busy", busy, 0);
    tick(4);
    send(4'h7, 1'b1, 0);
    tick(8);
    check("after_rst_data", data, 4'h7);
    for (int n = 0; n < 16; n++) begin
      d = 4'($urandom_range(0, 15));
      send(d, $urandom_range(0, 3) != 0, int'($urandom_range(0, 12)));
      tick(8 * int'($urandom_range(0, 2)));
    end
    for (int i = 0; i < 100 && q.size() != 0; i++) tick(1);
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
